// File: rtl/nios2_spi_slave.sv
// SPI slave (CPOL=0, CPHA=0, MSB first) with the same CPU register map, status
// and interrupt semantics as the companion 16-bit SPI master.
module nios2_spi_slave #(
    parameter int DATABITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                SCLK,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic                MISO_oe,
    input  logic                spi_select,
    input  logic [2:0]          mem_addr,
    input  logic                read_n,
    input  logic                write_n,
    input  logic [DATABITS-1:0] data_from_cpu,
    output logic [DATABITS-1:0] data_to_cpu,
    output logic                irq,
    output logic                dataavailable,
    output logic                readyfordata,
    output logic                endofpacket
);

    localparam int CNT_W = $clog2(DATABITS);
    localparam logic [CNT_W-1:0]    BITCNT_LAST = CNT_W'(DATABITS - 1);
    localparam logic [DATABITS-1:0] CTRL_MASK   = DATABITS'(10'h3D8);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // synchronizer and edge-detect registers
    logic sclk_ff1_q, sclk_ff2_q, sclk_prev_q;
    logic ss_ff1_q,   ss_ff2_q,   ss_prev_q;
    logic mosi_ff1_q, mosi_ff2_q;

    // shift engine registers
    state_t                state_q;
    logic [CNT_W-1:0]      bitcnt_q;
    logic [DATABITS-1:0]   shift_reg_q;
    logic                  mosi_bit_q;

    // CPU-visible registers and their next-state values
    logic                  rd_strobe_q, wr_strobe_q;
    logic [DATABITS-1:0]   tx_holding_q, tx_holding_d;
    logic                  tx_primed_q,  tx_primed_d;
    logic [DATABITS-1:0]   rx_holding_q, rx_holding_d;
    logic [DATABITS-1:0]   eop_value_q,  eop_value_d;
    logic [DATABITS-1:0]   ctrl_q,       ctrl_d;
    logic                  rrdy_q, rrdy_d;
    logic                  roe_q,  roe_d;
    logic                  toe_q,  toe_d;
    logic                  eop_q,  eop_d;
    logic [DATABITS-1:0]   data_to_cpu_q;
    logic                  irq_q;

    // combinational helpers
    logic                  sclk_rise_s, sclk_fall_s, ss_fall_s, ss_rise_s, active_s;
    logic                  start_s, word_done_s, load_tx_s;
    logic [DATABITS-1:0]   shift_in_s, reload_value_s;
    logic                  p1_rd_s, p1_wr_s;
    logic                  data_rd_s, p1_data_wr_s, data_wr_s, stat_wr_s, ctrl_wr_s, eopv_wr_s;
    logic                  primed_left_s, tx_accept_s, eop_hit_s;
    logic [DATABITS-1:0]   status_s, rd_mux_s;

    // Two-flop synchronizers plus previous-sample flops for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_ff1_q  <= 1'b0;
            sclk_ff2_q  <= 1'b0;
            sclk_prev_q <= 1'b0;
            ss_ff1_q    <= 1'b1;
            ss_ff2_q    <= 1'b1;
            ss_prev_q   <= 1'b1;
            mosi_ff1_q  <= 1'b0;
            mosi_ff2_q  <= 1'b0;
        end else begin
            sclk_ff1_q  <= SCLK;
            sclk_ff2_q  <= sclk_ff1_q;
            sclk_prev_q <= sclk_ff2_q;
            ss_ff1_q    <= SS_n;
            ss_ff2_q    <= ss_ff1_q;
            ss_prev_q   <= ss_ff2_q;
            mosi_ff1_q  <= MOSI;
            mosi_ff2_q  <= mosi_ff1_q;
        end
    end

    assign sclk_rise_s = sclk_ff2_q & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_ff2_q & sclk_prev_q;
    assign ss_fall_s   = ~ss_ff2_q & ss_prev_q;
    assign ss_rise_s   = ss_ff2_q & ~ss_prev_q;
    assign active_s    = ~ss_ff2_q;

    // Deselect has priority over a coincident last falling edge: the word is dropped.
    assign start_s        = (state_q == ST_IDLE) & ss_fall_s;
    assign word_done_s    = (state_q == ST_SHIFT) & ~ss_rise_s & sclk_fall_s & (bitcnt_q == BITCNT_LAST);
    assign load_tx_s      = tx_primed_q & (start_s | word_done_s);
    assign shift_in_s     = {shift_reg_q[DATABITS-2:0], mosi_bit_q};
    assign reload_value_s = tx_primed_q ? tx_holding_q : {DATABITS{1'b0}};

    // Shift engine FSM: frame start/stop, bit sampling, shifting and word reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= {CNT_W{1'b0}};
            shift_reg_q <= {DATABITS{1'b0}};
            mosi_bit_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_fall_s) begin
                        state_q     <= ST_SHIFT;
                        bitcnt_q    <= {CNT_W{1'b0}};
                        shift_reg_q <= reload_value_s;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise_s) begin
                        state_q  <= ST_IDLE;
                        bitcnt_q <= {CNT_W{1'b0}};
                    end else begin
                        if (sclk_rise_s) begin
                            mosi_bit_q <= mosi_ff2_q;
                        end
                        if (sclk_fall_s) begin
                            if (bitcnt_q == BITCNT_LAST) begin
                                shift_reg_q <= reload_value_s;
                                bitcnt_q    <= {CNT_W{1'b0}};
                            end else begin
                                shift_reg_q <= shift_in_s;
                                bitcnt_q    <= bitcnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    bitcnt_q <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign p1_rd_s      = ~rd_strobe_q & spi_select & ~read_n;
    assign p1_wr_s      = ~wr_strobe_q & spi_select & ~write_n;
    assign data_rd_s    = p1_rd_s & (mem_addr == 3'd0);
    assign p1_data_wr_s = p1_wr_s & (mem_addr == 3'd1);
    assign data_wr_s    = wr_strobe_q & (mem_addr == 3'd1);
    assign stat_wr_s    = wr_strobe_q & (mem_addr == 3'd2);
    assign ctrl_wr_s    = wr_strobe_q & (mem_addr == 3'd3);
    assign eopv_wr_s    = wr_strobe_q & (mem_addr == 3'd6);

    // A reload in the same cycle frees the holding register for a coincident CPU write.
    assign primed_left_s = tx_primed_q & ~load_tx_s;
    assign tx_accept_s   = data_wr_s & ~primed_left_s;
    assign eop_hit_s     = (data_rd_s & (rx_holding_q == eop_value_q))
                         | (p1_data_wr_s & (data_from_cpu == eop_value_q));

    // Next-state values of the CPU-visible registers; word-complete sets win over clears.
    always_comb begin
        rrdy_d       = word_done_s | (rrdy_q & ~data_rd_s & ~stat_wr_s);
        roe_d        = (word_done_s & rrdy_q) | (roe_q & ~stat_wr_s);
        toe_d        = (data_wr_s & primed_left_s) | (toe_q & ~stat_wr_s);
        eop_d        = eop_hit_s | (eop_q & ~stat_wr_s);
        tx_primed_d  = tx_accept_s | primed_left_s;
        tx_holding_d = tx_accept_s ? data_from_cpu : tx_holding_q;
        rx_holding_d = word_done_s ? shift_in_s : rx_holding_q;
        ctrl_d       = ctrl_wr_s ? (data_from_cpu & CTRL_MASK) : ctrl_q;
        eop_value_d  = eopv_wr_s ? data_from_cpu : eop_value_q;
    end

    // Status word and CPU read multiplexer.
    always_comb begin
        status_s    = {DATABITS{1'b0}};
        status_s[9] = eop_q;
        status_s[8] = roe_q | toe_q;
        status_s[7] = rrdy_q;
        status_s[6] = ~tx_primed_q;
        status_s[5] = ~active_s & ~tx_primed_q;
        status_s[4] = toe_q;
        status_s[3] = roe_q;
        case (mem_addr)
            3'd2:    rd_mux_s = status_s;
            3'd3:    rd_mux_s = ctrl_q;
            3'd6:    rd_mux_s = eop_value_q;
            default: rd_mux_s = rx_holding_q;
        endcase
    end

    // CPU register file, access strobes, read data and interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_strobe_q   <= 1'b0;
            wr_strobe_q   <= 1'b0;
            tx_holding_q  <= {DATABITS{1'b0}};
            tx_primed_q   <= 1'b0;
            rx_holding_q  <= {DATABITS{1'b0}};
            eop_value_q   <= {DATABITS{1'b0}};
            ctrl_q        <= {DATABITS{1'b0}};
            rrdy_q        <= 1'b0;
            roe_q         <= 1'b0;
            toe_q         <= 1'b0;
            eop_q         <= 1'b0;
            data_to_cpu_q <= {DATABITS{1'b0}};
            irq_q         <= 1'b0;
        end else begin
            rd_strobe_q   <= p1_rd_s;
            wr_strobe_q   <= p1_wr_s;
            tx_holding_q  <= tx_holding_d;
            tx_primed_q   <= tx_primed_d;
            rx_holding_q  <= rx_holding_d;
            eop_value_q   <= eop_value_d;
            ctrl_q        <= ctrl_d;
            rrdy_q        <= rrdy_d;
            roe_q         <= roe_d;
            toe_q         <= toe_d;
            eop_q         <= eop_d;
            irq_q         <= |(status_s & ctrl_q);
            if (p1_rd_s) begin
                data_to_cpu_q <= rd_mux_s;
            end
        end
    end

    assign MISO          = active_s & shift_reg_q[DATABITS-1];
    assign MISO_oe       = active_s;
    assign data_to_cpu   = data_to_cpu_q;
    assign irq           = irq_q;
    assign dataavailable = rrdy_q;
    assign readyfordata  = ~tx_primed_q;
    assign endofpacket   = eop_q;

endmodule

// File: tb/tb_nios2_spi_slave.sv
// Directed bench for nios2_spi_slave: a bench-side SPI master and CPU bus driver,
// a flag-level reference model, and a per-cycle compare process.
module tb_nios2_spi_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
    logic        MISO, MISO_oe;
    logic        spi_select = 1'b0;
    logic [2:0]  mem_addr = 3'd0;
    logic        read_n = 1'b1, write_n = 1'b1;
    logic [15:0] data_from_cpu = 16'h0000;
    logic [15:0] data_to_cpu;
    logic        irq, dataavailable, readyfordata, endofpacket;

    int n_checks = 0;
    int n_err    = 0;
    bit settled  = 1'b0;

    // reference model state
    bit          m_primed, m_rrdy, m_roe, m_toe, m_eop;
    logic [15:0] m_hold, m_rx, m_ctrl, m_eopval, m_cur;

    nios2_spi_slave #(.DATABITS(16)) dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select), .mem_addr(mem_addr),
        .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
        .readyfordata(readyfordata), .endofpacket(endofpacket)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s = (16'(m_eop) << 9) | (16'(m_roe | m_toe) << 8) | (16'(m_rrdy) << 7)
          | (16'(!m_primed) << 6) | (16'(!m_primed) << 5) | (16'(m_toe) << 4) | (16'(m_roe) << 3);
        return s;
    endfunction

    function automatic logic m_irq();
        return |(m_status() & m_ctrl);
    endfunction

    task automatic model_reset();
        m_primed = 1'b0; m_rrdy = 1'b0; m_roe = 1'b0; m_toe = 1'b0; m_eop = 1'b0;
        m_hold = 16'h0000; m_rx = 16'h0000; m_ctrl = 16'h0000; m_eopval = 16'h0000;
        m_cur = 16'h0000;
    endtask

    // per-cycle comparison of the flag outputs whenever the bus and SPI are quiet
    always @(negedge clk) begin
        if (settled) begin
            chk("rrdy_flag", dataavailable, m_rrdy);
            chk("trdy_flag", readyfordata, !m_primed);
            chk("eop_flag", endofpacket, m_eop);
            chk("irq_out", irq, m_irq());
            chk("miso_oe_idle", MISO_oe, !SS_n);
            chk("miso_idle", MISO, 1'b0);
        end
    end

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        settled = 1'b0;
        spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
        repeat (2) @(negedge clk);
        spi_select = 1'b0; write_n = 1'b1;
        case (a)
            3'd1: begin
                if (d == m_eopval) m_eop = 1'b1;
                if (!m_primed) begin m_hold = d; m_primed = 1'b1; end
                else m_toe = 1'b1;
            end
            3'd2: begin m_eop = 1'b0; m_rrdy = 1'b0; m_roe = 1'b0; m_toe = 1'b0; end
            3'd3: m_ctrl = d & 16'h03D8;
            3'd6: m_eopval = d;
            default: ;
        endcase
        repeat (2) @(negedge clk);
        settled = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] got);
        logic [15:0] exp;
        case (a)
            3'd2:    exp = m_status();
            3'd3:    exp = m_ctrl;
            3'd6:    exp = m_eopval;
            default: exp = m_rx;
        endcase
        settled = 1'b0;
        spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
        @(negedge clk);
        got = data_to_cpu;
        @(negedge clk);
        spi_select = 1'b0; read_n = 1'b1;
        chk("cpu_read", got, exp);
        if (a == 3'd0) begin
            if (m_rx == m_eopval) m_eop = 1'b1;
            m_rrdy = 1'b0;
        end
        repeat (2) @(negedge clk);
        settled = 1'b1;
    endtask

    task automatic frame_begin();
        settled = 1'b0;
        SS_n = 1'b0;
        m_cur = m_primed ? m_hold : 16'h0000;
        m_primed = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        SS_n = 1'b1;
        repeat (6) @(negedge clk);
        settled = 1'b1;
    endtask

    // master side: MOSI changes with SCLK falling, MISO sampled at SCLK rising
    task automatic shift_bits(input logic [15:0] w, input int nbits, output logic [15:0] got);
        got = 16'h0000;
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[15-i];
            repeat (4) @(negedge clk);
            got[15-i] = MISO;
            chk("miso_oe_active", MISO_oe, 1'b1);
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic xfer_word(input logic [15:0] w, output logic [15:0] got);
        shift_bits(w, 16, got);
        chk("miso_word", got, m_cur);
        if (m_rrdy) m_roe = 1'b1;
        m_rrdy = 1'b1;
        m_rx = w;
        m_cur = m_primed ? m_hold : 16'h0000;
        m_primed = 1'b0;
    endtask

    initial begin
        logic [15:0] r, mo;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        settled = 1'b1;
        chk("reset_oe", MISO_oe, 1'b0);
        chk("reset_rdata", data_to_cpu, 16'h0000);
        chk("reset_irq", irq, 1'b0);
        cpu_read(3'd2, r);
        chk("reset_status", r, 16'h0060);

        // basic word exchange
        cpu_write(3'd1, 16'hA5C3);
        frame_begin(); xfer_word(16'h1234, mo); frame_end();
        chk("t1_miso", mo, 16'hA5C3);
        cpu_read(3'd2, r); chk("t1_status_pre", r, 16'h00E0);
        cpu_read(3'd0, r); chk("t1_rx", r, 16'h1234);
        cpu_read(3'd2, r); chk("t1_status_post", r, 16'h0060);

        // receive overrun with iROE
        cpu_write(3'd3, 16'h0008);
        frame_begin(); xfer_word(16'h1111, mo); xfer_word(16'h2222, mo); frame_end();
        cpu_read(3'd2, r); chk("t2_status", r, 16'h01E8);
        chk("t2_irq", irq, 1'b1);
        cpu_read(3'd0, r); chk("t2_rx", r, 16'h2222);
        cpu_write(3'd2, 16'h0000);
        cpu_write(3'd3, 16'h0000);

        // transmit overrun
        cpu_write(3'd1, 16'h5A5A);
        cpu_write(3'd1, 16'h0F0F);
        cpu_read(3'd2, r); chk("t3_status_toe", r, 16'h0110);
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, r); chk("t3_status_clr", r, 16'h0000);
        frame_begin(); xfer_word(16'h3333, mo); frame_end();
        chk("t3_miso", mo, 16'h5A5A);
        cpu_read(3'd0, r);

        // partial word discarded
        frame_begin(); shift_bits(16'hFFFF, 7, mo); frame_end();
        cpu_read(3'd2, r); chk("t4_status", r, 16'h0060);
        frame_begin(); xfer_word(16'hC0DE, mo); frame_end();
        cpu_read(3'd0, r); chk("t4_rx", r, 16'hC0DE);

        // end-of-packet on read, underrun shifts zeros
        cpu_write(3'd6, 16'hBEEF);
        frame_begin(); xfer_word(16'hBEEF, mo); frame_end();
        chk("t5_miso", mo, 16'h0000);
        cpu_read(3'd0, r); chk("t5_rx", r, 16'hBEEF);
        chk("t5_eop", endofpacket, 1'b1);
        cpu_read(3'd2, r); chk("t5_status", r, 16'h0260);
        cpu_write(3'd2, 16'h0000);

        // reset in the middle of a frame
        cpu_write(3'd1, 16'h2468);
        frame_begin(); shift_bits(16'hAAAA, 5, mo);
        reset = 1'b1; SS_n = 1'b1; SCLK = 1'b0;
        @(negedge clk);
        chk("t6_oe", MISO_oe, 1'b0);
        chk("t6_rrdy", dataavailable, 1'b0);
        chk("t6_trdy", readyfordata, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        settled = 1'b1;
        cpu_read(3'd2, r); chk("t6_status", r, 16'h0060);
        cpu_write(3'd1, 16'h1357);
        frame_begin(); xfer_word(16'h7E81, mo); frame_end();
        chk("t6_miso", mo, 16'h1357);
        cpu_read(3'd0, r); chk("t6_rx", r, 16'h7E81);

        settled = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
